sa_1d: RTL and testbench

//  3-tap 1-D convolution (correlation) engine built as a systolic row of three PEs.
//  - Consumes one data sample per valid cycle and adds an incoming partial sum.
//  - Emits one 16-bit partial sum per full 3-sample window.
//  - Sits in the CNN conv datapath; psum_in/psum_out allow chaining for multi-channel accumulation.

---
 rtl/sa_1d_pkg.sv | 6 +
 rtl/sa_1d_pe.sv | 38 +++
 rtl/sa_1d.sv | 98 +++++++++
 tb/tb_sa_1d.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sa_1d_pkg.sv
// Shared sizing for the 3-tap systolic 1-D convolution row.
package sa_1d_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int PSUM_WIDTH = 16;
  localparam int NUM_TAPS   = 3;
endpackage

// File: rtl/sa_1d_pe.sv
// One systolic PE: a tap register that shifts on accept, feeding a registered multiplier.
module sa_1d_pe
  import sa_1d_pkg::*;
#(
  parameter int DATA_WIDTH = sa_1d_pkg::DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      shift_en,
  input  logic [DATA_WIDTH-1:0]     tap_in,
  input  logic [DATA_WIDTH-1:0]     weight,
  output logic [DATA_WIDTH-1:0]     tap_out,
  output logic [2*DATA_WIDTH-1:0]   prod_out
);
  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] tap_q, tap_d;
  logic [PROD_W-1:0]     prod_q, prod_d;

  always_comb begin
    tap_d  = shift_en ? tap_in : tap_q;
    prod_d = PROD_W'(weight) * PROD_W'(tap_q);
  end

  // S1 tap capture | S2 product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q  <= '0;
      prod_q <= '0;
    end else begin
      tap_q  <= tap_d;
      prod_q <= prod_d;
    end
  end

  assign tap_out  = tap_q;
  assign prod_out = prod_q;
endmodule

// File: rtl/sa_1d.sv
// 3-tap unsigned 1-D correlation: y = psum_in + w0*x[n-2] + w1*x[n-1] + w2*x[n], mod 2^16.
module sa_1d
  import sa_1d_pkg::*;
#(
  parameter int DATA_WIDTH = sa_1d_pkg::DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [DATA_WIDTH-1:0]  weight_in0,
  input  logic [DATA_WIDTH-1:0]  weight_in1,
  input  logic [DATA_WIDTH-1:0]  weight_in2,
  input  logic [PSUM_WIDTH-1:0]  psum_in,
  output logic                   valid_out,
  output logic [PSUM_WIDTH-1:0]  psum_out
);
  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int SUM_W   = ((PROD_W > PSUM_WIDTH) ? PROD_W : PSUM_WIDTH) + 2;
  localparam int CNT_W   = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_TAPS - 1);

  function automatic logic [PSUM_WIDTH-1:0] wrap_psum(input logic [SUM_W-1:0] s);
    return s[PSUM_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] weights   [NUM_TAPS];
  logic [DATA_WIDTH-1:0] shift_src [NUM_TAPS+1];
  logic [PROD_W-1:0]     prod      [NUM_TAPS];
  logic                  unused_tail;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [PSUM_WIDTH-1:0] psum_p1_q, psum_p1_d, psum_p2_q, psum_p2_d;
  logic                  valid_out_q, valid_out_d;
  logic [PSUM_WIDTH-1:0] psum_out_q, psum_out_d;
  logic [SUM_W-1:0]      sum;

  // PE0 holds the newest sample, so the weight order is reversed along the row
  always_comb begin
    weights[0] = weight_in2;
    weights[1] = weight_in1;
    weights[2] = weight_in0;
  end

  assign shift_src[0] = data_in;
  assign unused_tail  = ^shift_src[NUM_TAPS];

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_pe
    sa_1d_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (valid_in),
      .tap_in   (shift_src[i]),
      .weight   (weights[i]),
      .tap_out  (shift_src[i+1]),
      .prod_out (prod[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_in && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    vld_p1_d  = valid_in && (cnt_q >= CNT_FULL);
    psum_p1_d = valid_in ? psum_in : psum_p1_q;
    vld_p2_d  = vld_p1_q;
    psum_p2_d = psum_p1_q;
    sum = SUM_W'(psum_p2_q);
    for (int i = 0; i < NUM_TAPS; i++) sum = sum + SUM_W'(prod[i]);
    valid_out_d = vld_p2_q;
    psum_out_d  = vld_p2_q ? wrap_psum(sum) : psum_out_q;
  end

  // S1 count/psum capture | S2 carry | S3 adder tree into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      vld_p1_q    <= 1'b0;
      psum_p1_q   <= '0;
      vld_p2_q    <= 1'b0;
      psum_p2_q   <= '0;
      valid_out_q <= 1'b0;
      psum_out_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      vld_p1_q    <= vld_p1_d;
      psum_p1_q   <= psum_p1_d;
      vld_p2_q    <= vld_p2_d;
      psum_p2_q   <= psum_p2_d;
      valid_out_q <= valid_out_d;
      psum_out_q  <= psum_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign psum_out  = psum_out_q;
endmodule

// File: tb/tb_sa_1d.sv
// Scoreboard bench for sa_1d: a window model queues expected results, a monitor checks them.
module tb_sa_1d;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  weight_in0 = '0, weight_in1 = '0, weight_in2 = '0;
  logic [15:0] psum_in = '0;
  logic        valid_out;
  logic [15:0] psum_out;

  typedef struct {logic [15:0] val; int due;} exp_t;
  exp_t        exp_q[$];
  int unsigned hist[$];
  logic [15:0] hold_val = '0;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  sa_1d dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .weight_in0(weight_in0), .weight_in1(weight_in1), .weight_in2(weight_in2),
    .psum_in(psum_in), .valid_out(valid_out), .psum_out(psum_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Window model: last three accepted samples, oldest first.
  task automatic model_accept(input int unsigned d, input int unsigned p);
    int unsigned y;
    exp_t e;
    hist.push_back(d);
    if (hist.size() > 3) void'(hist.pop_front());
    if (hist.size() == 3) begin
      y = p + weight_in0 * hist[0] + weight_in1 * hist[1] + weight_in2 * hist[2];
      e.val = y[15:0];
      e.due = cyc + 3;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic v, input logic [7:0] d, input logic [15:0] p);
    @(posedge clk); #1;
    valid_in = v; data_in = d; psum_in = p;
    if (v) model_accept(d, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, $urandom_range(0, 255), 16'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; valid_in = 1'b0;
    exp_q.delete(); hist.delete(); hold_val = '0;
    #1;
    chk("async_rst_valid", valid_out, 0);
    chk("async_rst_psum", psum_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_w(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    weight_in0 = a; weight_in1 = b; weight_in2 = c;
  endtask

  task automatic drain_check(input string name);
    idle(5);
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_valid_out", valid_out, 0);
      chk("reset_psum_out", psum_out, 0);
    end else if (valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("psum_out", psum_out, e.val);
        chk("latency_cycle", cyc, e.due);
        hold_val = e.val;
      end
    end else begin
      chk("psum_hold", psum_out, hold_val);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int stream[10] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
    // Reset held 12 ns with random inputs
    valid_in = 1'b1; data_in = 8'($urandom); psum_in = 16'($urandom);
    set_w(8'($urandom), 8'($urandom), 8'($urandom));
    #6 data_in = 8'($urandom); psum_in = 16'($urandom);
    #6 valid_in = 1'b0; rst_n = 1'b1;

    // Consecutive stream
    set_w(1, 2, 3);
    for (int i = 0; i < 10; i++) send(1'b1, 8'(stream[i]), 16'd0);
    drain_check("stream_drain");

    // Same stream with bubbles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 8'(stream[i]), 16'd0);
      idle($urandom_range(1, 3));
    end
    drain_check("bubble_drain");

    // psum_in contribution
    do_reset();
    set_w(1, 1, 1);
    send(1'b1, 8'd1, 16'd0);
    send(1'b1, 8'd2, 16'd0);
    send(1'b1, 8'd3, 16'd100);
    drain_check("psum_drain");

    // Overflow wraps mod 2^16
    do_reset();
    set_w(255, 255, 255);
    for (int i = 0; i < 3; i++) send(1'b1, 8'd255, 16'd0);
    drain_check("overflow_drain");

    // Mid-stream reset, then restart with fresh samples
    do_reset();
    set_w(1, 2, 3);
    for (int i = 0; i < 4; i++) send(1'b1, 8'(stream[i]), 16'd0);
    do_reset();
    for (int i = 4; i < 8; i++) send(1'b1, 8'(stream[i]), 16'd0);
    drain_check("midreset_drain");

    // Randomized stream with random weights, psum and gaps
    do_reset();
    set_w(8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 300; i++)
      send(1'($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom));
    drain_check("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
